// File: rtl/pipe_stage_skid.sv
// EX/MEM pipeline stage with a one-entry skid buffer.
// in_ready is decoded from registered state only, so no combinational path
// runs from out_ready back to in_ready. When no entry is valid, out_ctrl is
// forced to zero so downstream sees a NOP bubble. bubble_cnt saturates
// instead of wrapping.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (accept = in_valid && in_ready, take = out_valid && out_ready).
// A producer holds its entry stable while valid is high and ready is low.
// flush overrides every other event. A take on the same edge as a flush
// still counts as delivered, because the downstream stage owns that handoff.
module pipe_stage_skid #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 5,
   parameter int RD_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [RD_W-1:0]   out_rd,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, out_valid_q;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [RD_W-1:0]     main_rd_q, main_rd_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [RD_W-1:0]     skid_rd_q, skid_rd_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CNT_W-1:0]    bubble_q, bubble_d;

   logic                accept;
   logic                take;

   assign accept = in_valid && in_ready_q;
   assign take   = out_valid_q && out_ready;

   // Next state and next payloads. Flush empties the stage but leaves the
   // payload registers untouched, since out_ctrl masking already hides them.
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_rd_d   = main_rd_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_rd_d   = skid_rd_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_ctrl_d = in_ctrl;
                  main_rd_d   = in_rd;
                  main_data_d = in_data;
                  state_d     = ST_FULL;
               end
            end
            ST_FULL: begin
               if (accept && take) begin
                  main_ctrl_d = in_ctrl;
                  main_rd_d   = in_rd;
                  main_data_d = in_data;
               end else if (accept) begin
                  skid_ctrl_d = in_ctrl;
                  skid_rd_d   = in_rd;
                  skid_data_d = in_data;
                  state_d     = ST_SKID;
               end else if (take) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (take) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_rd_d   = skid_rd_q;
                  main_data_d = skid_data_q;
                  state_d     = ST_FULL;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Count a bubble when downstream is ready but nothing valid is offered.
   // The counter stops at its all-ones value instead of wrapping.
   always_comb begin
      bubble_d = bubble_q;
      if (!out_valid_q && out_ready && !flush && (bubble_q != {CNT_W{1'b1}}))
         bubble_d = bubble_q + CNT_W'(1);
   end

   // State, payload and counter registers. The handshake flags are
   // registered from the next state, so they depend on state alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_ctrl_q <= '0;
         main_rd_q   <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_rd_q   <= '0;
         skid_data_q <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d != ST_SKID);
         out_valid_q <= (state_d != ST_EMPTY);
         main_ctrl_q <= main_ctrl_d;
         main_rd_q   <= main_rd_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_rd_q   <= skid_rd_d;
         skid_data_q <= skid_data_d;
         bubble_q    <= bubble_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_ctrl   = out_valid_q ? main_ctrl_q : '0;
   assign out_rd     = main_rd_q;
   assign out_data   = main_data_q;
   assign bubble_cnt = bubble_q;
   assign state_o    = state_q;

endmodule
